// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM states and owner encoding for the memory bus arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_USER = 2'd1,
    GNT_CU   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_USER = 1'b0,
    OWNER_CU   = 1'b1
  } owner_e;

  typedef enum logic {
    POLICY_FIXED = 1'b0,
    POLICY_RR    = 1'b1
  } policy_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWNER_USER) ? OWNER_CU : OWNER_USER;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way winner selection between user and control-unit requests.
// Fixed policy favours the control unit; round-robin favours whoever did not win last.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter policy_e POLICY = POLICY_FIXED
) (
  input  logic   user_elig_i,
  input  logic   cu_elig_i,
  input  owner_e last_winner_i,
  output logic   valid_o,
  output owner_e winner_o
);

  always_comb begin
    valid_o  = user_elig_i | cu_elig_i;
    winner_o = OWNER_USER;
    if (user_elig_i && cu_elig_i) begin
      winner_o = (POLICY == POLICY_RR) ? other_owner(last_winner_i) : OWNER_CU;
    end else if (cu_elig_i) begin
      winner_o = OWNER_CU;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a single 16x8 memory bus between a loader (user) port and a control-unit port.
// Define MEM_BUS_ARBITER_RR_EN for round-robin conflict resolution; default is CU priority.
module mem_bus_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              op,
  input  logic              user_req,
  input  logic              user_we,
  input  logic [ADDR_W-1:0] user_addr,
  input  logic [DATA_W-1:0] user_wdata,
  output logic              user_gnt,
  output logic              user_rvalid,
  output logic [DATA_W-1:0] user_rdata,
  input  logic              cu_req,
  input  logic              cu_we,
  input  logic [ADDR_W-1:0] cu_addr,
  input  logic [DATA_W-1:0] cu_wdata,
  output logic              cu_gnt,
  output logic              cu_rvalid,
  output logic [DATA_W-1:0] cu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              user_rvalid_q, user_rvalid_d;
  logic              cu_rvalid_q, cu_rvalid_d;
  logic [DATA_W-1:0] user_rdata_q, user_rdata_d;
  logic [DATA_W-1:0] cu_rdata_q, cu_rdata_d;
  logic              pick_valid;
  owner_e            pick_winner;
  owner_e            last_winner;

`ifdef MEM_BUS_ARBITER_RR_EN
  localparam policy_e POLICY = POLICY_RR;
  owner_e last_winner_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner_q <= OWNER_USER;
    end else if (state_q == IDLE && pick_valid) begin
      last_winner_q <= pick_winner;
    end
  end

  assign last_winner = last_winner_q;
`else
  localparam policy_e POLICY = POLICY_FIXED;
  assign last_winner = OWNER_USER;
`endif

  // op only matters at arbitration time, so a change mid-grant never disturbs a transfer.
  mem_arb_pick #(
    .POLICY(POLICY)
  ) u_pick (
    .user_elig_i  (user_req),
    .cu_elig_i    (cu_req & op),
    .last_winner_i(last_winner),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  always_comb begin
    state_d       = state_q;
    user_gnt      = 1'b0;
    cu_gnt        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_we        = 1'b0;
    user_rvalid_d = 1'b0;
    cu_rvalid_d   = 1'b0;
    user_rdata_d  = user_rdata_q;
    cu_rdata_d    = cu_rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = (pick_winner == OWNER_CU) ? GNT_CU : GNT_USER;
        end
      end
      GNT_USER: begin
        user_gnt  = 1'b1;
        mem_addr  = user_addr;
        mem_wdata = user_wdata;
        mem_we    = user_we;
        state_d   = IDLE;
        if (!user_we) begin
          user_rvalid_d = 1'b1;
          user_rdata_d  = mem_rdata;
        end
      end
      GNT_CU: begin
        cu_gnt    = 1'b1;
        mem_addr  = cu_addr;
        mem_wdata = cu_wdata;
        mem_we    = cu_we;
        state_d   = IDLE;
        if (!cu_we) begin
          cu_rvalid_d = 1'b1;
          cu_rdata_d  = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is registered so mem_rdata never reaches an output combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      user_rvalid_q <= 1'b0;
      cu_rvalid_q   <= 1'b0;
      user_rdata_q  <= '0;
      cu_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      user_rvalid_q <= user_rvalid_d;
      cu_rvalid_q   <= cu_rvalid_d;
      user_rdata_q  <= user_rdata_d;
      cu_rdata_q    <= cu_rdata_d;
    end
  end

  assign user_rvalid = user_rvalid_q;
  assign cu_rvalid   = cu_rvalid_q;
  assign user_rdata  = user_rdata_q;
  assign cu_rdata    = cu_rdata_q;

endmodule
